uart_frame_responder: RTL and testbench

Periodic UART response-frame generator that sits between the NANDLAND-style uart_rx and uart_tx instances at board top level. It tracks received bytes and mirrors the latest one on the LEDs. Every SLEEP_TICKS cycles it builds a frame of up to BUFFER_BYTE_SIZE bytes and serialises it one byte at a time through the tx DV/done handshake. It adds runtime frame length, a selectable payload mode, an optional XOR checksum byte and overrun detection, with the byte sequencer built in.

---
 rtl/uart_frame_responder.sv | 147 ++++++++++++++
 tb/tb_uart_frame_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_responder.sv
// Periodic UART response-frame generator: tracks rx bytes, mirrors the latest on LEDs,
// and every SLEEP_TICKS cycles serialises a payload (plus optional XOR checksum) to uart_tx.
module uart_frame_responder #(
  parameter int unsigned BUFFER_BYTE_SIZE  = 3,
  parameter int unsigned BUFFER_INDEX_SIZE = 32,
  parameter int unsigned SLEEP_TICKS       = 100000000,
  parameter int unsigned MODE              = 0,
  parameter int unsigned APPEND_CHECKSUM   = 0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         rx_ready,
  input  logic [7:0]                   rx_data,
  input  logic                         tx_done,
  input  logic                         enable,
  input  logic [BUFFER_INDEX_SIZE-1:0] byte_count,
  output logic                         is_tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         busy,
  output logic [7:0]                   leds,
  output logic [7:0]                   overrun_count
);

  localparam int unsigned TICK_W    = (SLEEP_TICKS > 1) ? $clog2(SLEEP_TICKS) : 1;
  localparam int unsigned FRAME_MAX = BUFFER_BYTE_SIZE + APPEND_CHECKSUM;
  localparam int unsigned IDX_W     = $clog2(FRAME_MAX + 1) + 1;
  localparam int unsigned DEPTH     = 1 << IDX_W;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

  state_t             state;
  logic [TICK_W-1:0]  tick_cnt;
  logic [7:0]         last_rx;
  logic [7:0]         history [BUFFER_BYTE_SIZE];
  logic [7:0]         frame_buf [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_idx;

  logic               trigger_c;
  logic               valid_trig_c;
  logic [IDX_W-1:0]   n_c;
  logic [IDX_W-1:0]   total_c;
  logic [7:0]         pay_c [BUFFER_BYTE_SIZE];
  logic [7:0]         frame_c [DEPTH];
  logic [7:0]         csum_c;

  assign leds = last_rx;

  // Free-running frame period counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
    end else if (trigger_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign trigger_c = (tick_cnt == TICK_W'(SLEEP_TICKS - 1));

  // Receive tracking: latest byte plus newest-first history
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_rx <= 8'h00;
      for (int k = 0; k < int'(BUFFER_BYTE_SIZE); k++) history[k] <= 8'h00;
    end else if (rx_ready) begin
      last_rx <= rx_data;
      for (int k = int'(BUFFER_BYTE_SIZE) - 1; k > 0; k--) history[k] <= history[k-1];
      history[0] <= rx_data;
    end
  end

  // Clamp requested length to the buffer size
  always_comb begin
    n_c = IDX_W'(BUFFER_BYTE_SIZE);
    if (byte_count < BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE)) n_c = IDX_W'(byte_count);
    total_c      = n_c + IDX_W'(APPEND_CHECKSUM);
    valid_trig_c = trigger_c && enable && (n_c != '0);
  end

  // Frame image built from pre-edge rx state; checksum lands right after the payload
  always_comb begin
    csum_c = 8'h00;
    for (int k = 0; k < int'(BUFFER_BYTE_SIZE); k++) begin
      pay_c[k] = (MODE == 1) ? history[k] : last_rx + 8'(k + 1);
      if (IDX_W'(k) < n_c) csum_c = csum_c ^ pay_c[k];
    end
    for (int k = 0; k < int'(DEPTH); k++) frame_c[k] = 8'h00;
    for (int k = 0; k < int'(BUFFER_BYTE_SIZE); k++) frame_c[k] = pay_c[k];
    for (int k = 0; k < int'(DEPTH); k++) begin
      if ((APPEND_CHECKSUM != 0) && (IDX_W'(k) == n_c)) frame_c[k] = csum_c;
    end
  end

  // Byte sequencer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      idx           <= '0;
      last_idx      <= '0;
      is_tx_ready   <= 1'b0;
      tx_data       <= 8'h00;
      busy          <= 1'b0;
      overrun_count <= 8'h00;
      for (int k = 0; k < int'(DEPTH); k++) frame_buf[k] <= 8'h00;
    end else begin
      is_tx_ready <= 1'b0;
      if (valid_trig_c && busy && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'h01;
      end
      case (state)
        ST_IDLE: begin
          if (valid_trig_c) begin
            for (int k = 0; k < int'(DEPTH); k++) frame_buf[k] <= frame_c[k];
            idx         <= '0;
            last_idx    <= total_c - IDX_W'(1);
            busy        <= 1'b1;
            is_tx_ready <= 1'b1;
            tx_data     <= frame_c[0];
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (idx == last_idx) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              idx         <= idx + IDX_W'(1);
              is_tx_ready <= 1'b1;
              tx_data     <= frame_buf[idx + IDX_W'(1)];
              state       <= ST_SEND;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_responder.sv
// Directed bench for uart_frame_responder: three instances (increment, increment+checksum,
// echo history) sharing clock and reset, each with its own handshake signals.
module tb_uart_frame_responder;

  logic        CLK;
  logic        RST_N;
  logic        rx_ready_a    [3];
  logic [7:0]  rx_data_a     [3];
  logic        tx_done_a     [3];
  logic        enable_a      [3];
  logic [31:0] byte_count_a  [3];
  logic        is_tx_ready_a [3];
  logic [7:0]  tx_data_a     [3];
  logic        busy_a        [3];
  logic [7:0]  leds_a        [3];
  logic [7:0]  ovr_a         [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] exp_q [$];

  uart_frame_responder #(.BUFFER_BYTE_SIZE(3), .BUFFER_INDEX_SIZE(32), .SLEEP_TICKS(16),
                         .MODE(0), .APPEND_CHECKSUM(0)) u0 (
    .CLK(CLK), .RST_N(RST_N), .rx_ready(rx_ready_a[0]), .rx_data(rx_data_a[0]),
    .tx_done(tx_done_a[0]), .enable(enable_a[0]), .byte_count(byte_count_a[0]),
    .is_tx_ready(is_tx_ready_a[0]), .tx_data(tx_data_a[0]), .busy(busy_a[0]),
    .leds(leds_a[0]), .overrun_count(ovr_a[0]));

  uart_frame_responder #(.BUFFER_BYTE_SIZE(3), .BUFFER_INDEX_SIZE(32), .SLEEP_TICKS(16),
                         .MODE(0), .APPEND_CHECKSUM(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .rx_ready(rx_ready_a[1]), .rx_data(rx_data_a[1]),
    .tx_done(tx_done_a[1]), .enable(enable_a[1]), .byte_count(byte_count_a[1]),
    .is_tx_ready(is_tx_ready_a[1]), .tx_data(tx_data_a[1]), .busy(busy_a[1]),
    .leds(leds_a[1]), .overrun_count(ovr_a[1]));

  uart_frame_responder #(.BUFFER_BYTE_SIZE(3), .BUFFER_INDEX_SIZE(32), .SLEEP_TICKS(16),
                         .MODE(1), .APPEND_CHECKSUM(0)) u2 (
    .CLK(CLK), .RST_N(RST_N), .rx_ready(rx_ready_a[2]), .rx_data(rx_data_a[2]),
    .tx_done(tx_done_a[2]), .enable(enable_a[2]), .byte_count(byte_count_a[2]),
    .is_tx_ready(is_tx_ready_a[2]), .tx_data(tx_data_a[2]), .busy(busy_a[2]),
    .leds(leds_a[2]), .overrun_count(ovr_a[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic rx_pulse(input int inst, input logic [7:0] d);
    rx_ready_a[inst] = 1'b1;
    rx_data_a[inst]  = d;
    tick();
    rx_ready_a[inst] = 1'b0;
  endtask

  task automatic wait_strobe(input int inst);
    int n = 0;
    while (is_tx_ready_a[inst] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("strobe_seen", 32'(is_tx_ready_a[inst]), 32'd1);
  endtask

  task automatic count_strobes(input int inst, input int ncyc, output int strobes);
    strobes = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (is_tx_ready_a[inst] === 1'b1) strobes++;
    end
  endtask

  // Answers each strobe with tx_done five cycles later and checks bytes from exp_q
  task automatic serve(input int inst);
    wait_strobe(inst);
    byte_count_a[inst] = 32'd0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk("tx_byte", 32'(tx_data_a[inst]), 32'(exp_q[k]));
      chk("busy_in_frame", 32'(busy_a[inst]), 32'd1);
      tick();
      chk("strobe_width", 32'(is_tx_ready_a[inst]), 32'd0);
      repeat (4) tick();
      tx_done_a[inst] = 1'b1;
      tick();
      tx_done_a[inst] = 1'b0;
      if (k < exp_q.size() - 1) begin
        chk("next_strobe", 32'(is_tx_ready_a[inst]), 32'd1);
      end else begin
        chk("busy_drop", 32'(busy_a[inst]), 32'd0);
        chk("no_extra_strobe", 32'(is_tx_ready_a[inst]), 32'd0);
      end
    end
  endtask

  initial begin
    int s;
    int n;
    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_ready_a[i] = 1'b0; rx_data_a[i] = 8'h00; tx_done_a[i] = 1'b0;
      enable_a[i] = 1'b1; byte_count_a[i] = 32'd0;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_strobe", 32'(is_tx_ready_a[i]), 32'd0);
      chk("rst_txdata", 32'(tx_data_a[i]), 32'd0);
      chk("rst_busy", 32'(busy_a[i]), 32'd0);
      chk("rst_leds", 32'(leds_a[i]), 32'd0);
      chk("rst_ovr", 32'(ovr_a[i]), 32'd0);
    end
    RST_N = 1'b1;
    cyc = 0;

    // Increment mode, three bytes, first strobe in cycle 16
    byte_count_a[0] = 32'd3;
    tick_to(2);
    rx_pulse(0, 8'h41);
    chk("leds_rx", 32'(leds_a[0]), 32'h41);
    tick_to(15);
    chk("pre_trigger_strobe", 32'(is_tx_ready_a[0]), 32'd0);
    chk("pre_trigger_busy", 32'(busy_a[0]), 32'd0);
    tick();
    chk("first_strobe_c16", 32'(is_tx_ready_a[0]), 32'd1);
    exp_q = '{8'h42, 8'h43, 8'h44};
    serve(0);

    // Increment with wrap and checksum
    tick_to(34);
    byte_count_a[1] = 32'd3;
    rx_pulse(1, 8'hFE);
    tick_to(47);
    chk("cs_idle_before", 32'(busy_a[1]), 32'd0);
    exp_q = '{8'hFF, 8'h00, 8'h01, 8'hFE};
    serve(1);
    chk("cs_ovr", 32'(ovr_a[1]), 32'd0);

    // Echo history, length 2 then clamped 7 -> 3, rx in trigger cycle deferred
    byte_count_a[2] = 32'd2;
    tick_to(73); rx_pulse(2, 8'h10);
    tick_to(75); rx_pulse(2, 8'h20);
    tick_to(77); rx_pulse(2, 8'h30);
    exp_q = '{8'h30, 8'h20};
    serve(2);
    byte_count_a[2] = 32'd7;
    tick_to(95);
    rx_pulse(2, 8'h55);
    exp_q = '{8'h30, 8'h20, 8'h10};
    serve(2);
    chk("hist_leds", 32'(leds_a[2]), 32'h55);
    byte_count_a[2] = 32'd2;
    exp_q = '{8'h55, 8'h30};
    serve(2);
    chk("hist_ovr", 32'(ovr_a[2]), 32'd0);

    // enable=0 and count=0 both suppress frames without overrun
    enable_a[2] = 1'b0;
    byte_count_a[2] = 32'd3;
    count_strobes(2, 48, s);
    chk("disabled_strobes", 32'(s), 32'd0);
    chk("disabled_busy", 32'(busy_a[2]), 32'd0);
    enable_a[2] = 1'b1;
    byte_count_a[2] = 32'd0;
    count_strobes(2, 48, s);
    chk("zero_count_strobes", 32'(s), 32'd0);
    chk("zero_count_ovr", 32'(ovr_a[2]), 32'd0);

    // Dropping enable mid-frame lets the frame finish
    byte_count_a[2] = 32'd2;
    wait_strobe(2);
    enable_a[2] = 1'b0;
    exp_q = '{8'h55, 8'h30};
    serve(2);
    chk("enable_drop_ovr", 32'(ovr_a[2]), 32'd0);

    // Withheld tx_done: two dropped triggers, frame intact
    byte_count_a[0] = 32'd2;
    wait_strobe(0);
    chk("ovr_first_byte", 32'(tx_data_a[0]), 32'h42);
    count_strobes(0, 40, s);
    byte_count_a[0] = 32'd0;
    chk("ovr_no_strobes", 32'(s), 32'd0);
    chk("ovr_count2", 32'(ovr_a[0]), 32'd2);
    chk("ovr_data_stable", 32'(tx_data_a[0]), 32'h42);
    chk("ovr_busy", 32'(busy_a[0]), 32'd1);
    tx_done_a[0] = 1'b1;
    tick();
    tx_done_a[0] = 1'b0;
    exp_q = '{8'h43};
    serve(0);
    chk("ovr_count_after", 32'(ovr_a[0]), 32'd2);

    // Overrun counter saturates at 255
    byte_count_a[1] = 32'd1;
    wait_strobe(1);
    n = 0;
    while (ovr_a[1] !== 8'hFF && n < 5000) begin
      tick();
      n++;
    end
    chk("ovr_reach_255", 32'(ovr_a[1]), 32'hFF);
    repeat (40) tick();
    chk("ovr_saturate", 32'(ovr_a[1]), 32'hFF);
    chk("sat_busy", 32'(busy_a[1]), 32'd1);
    chk("sat_data", 32'(tx_data_a[1]), 32'hFF);

    // Asynchronous reset mid-cycle while in WAIT
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_busy", 32'(busy_a[1]), 32'd0);
    chk("async_strobe", 32'(is_tx_ready_a[1]), 32'd0);
    chk("async_leds", 32'(leds_a[1]), 32'd0);
    chk("async_ovr", 32'(ovr_a[1]), 32'd0);
    chk("async_txdata", 32'(tx_data_a[1]), 32'd0);
    chk("async_ovr_u0", 32'(ovr_a[0]), 32'd0);
    byte_count_a[1] = 32'd0;
    tick();
    tick();
    RST_N = 1'b1;
    cyc = 0;
    byte_count_a[0] = 32'd1;
    tick_to(15);
    chk("post_rst_no_strobe", 32'(is_tx_ready_a[0]), 32'd0);
    tick();
    chk("post_rst_strobe_c16", 32'(is_tx_ready_a[0]), 32'd1);
    exp_q = '{8'h01};
    serve(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
